// File: rtl/ph_update_scheduler.sv
// ph_update_scheduler
//   Sequences every write into the per-router ACO pheromone table, which takes
//   one command per cycle. Backward-ant updates from N input ports are held in
//   one slot per port and granted round-robin. A periodic evaporation sweep
//   (one command per destination row) is interleaved at command boundaries.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   i_upd_valid[i]      port i offers an update (dest, amount)
//   i_upd_dest[i]       destination row of the ant
//   i_upd_amount[i]     pheromone increment (0 = accepted and dropped)
//   o_upd_ready[i]      port i holding slot is free
//   o_cmd_valid         table command valid (registered)
//   i_cmd_ready         table accepts the command this cycle
//   o_cmd_evap          1 = evaporate o_cmd_row, 0 = update
//   o_cmd_row           target row
//   o_cmd_port          requesting port (0 for evaporation)
//   o_cmd_amount        increment, passed through (0 for evaporation)
//   o_busy              scheduler is not idle

// One holding slot per input port.
module ph_upd_slot #(
    parameter int RW    = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [RW-1:0]    in_dest,
    input  logic [AMT_W-1:0] in_amount,
    input  logic             clr,
    output logic             pending,
    output logic [RW-1:0]    dest,
    output logic [AMT_W-1:0] amount
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            dest    <= '0;
            amount  <= '0;
        end else if (clr) begin
            pending <= 1'b0;
        end else if (in_valid && !pending) begin
            // A zero-amount ant is taken off the port but has nothing to write.
            if (in_amount != '0) begin
                pending <= 1'b1;
                dest    <= in_dest;
                amount  <= in_amount;
            end
        end
    end

endmodule

module ph_update_scheduler #(
    parameter int N           = 5,
    parameter int NODES       = 16,
    parameter int AMT_W       = 3,
    parameter int EVAP_PERIOD = 256
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [0:N-1]                          i_upd_valid,
    input  logic [0:N-1][$clog2(NODES)-1:0]       i_upd_dest,
    input  logic [0:N-1][AMT_W-1:0]               i_upd_amount,
    output logic [0:N-1]                          o_upd_ready,
    output logic                                  o_cmd_valid,
    input  logic                                  i_cmd_ready,
    output logic                                  o_cmd_evap,
    output logic [$clog2(NODES)-1:0]              o_cmd_row,
    output logic [$clog2(N)-1:0]                  o_cmd_port,
    output logic [AMT_W-1:0]                      o_cmd_amount,
    output logic                                  o_busy
);

    localparam int RW = $clog2(NODES);
    localparam int PW = $clog2(N);
    localparam int TW = $clog2(EVAP_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_UPD, S_EVAP} state_t;

    state_t                      state_q, state_d;
    logic [N-1:0]                pend;
    logic [N-1:0]                slot_clr;
    logic [N-1:0][RW-1:0]        slot_dest;
    logic [N-1:0][AMT_W-1:0]     slot_amt;
    logic [PW-1:0]               rr_ptr;
    logic [PW-1:0]               gnt_idx;
    logic                        any_pend;
    logic [TW-1:0]               evap_cnt;
    logic                        evap_wrap;
    logic                        evap_req;
    logic                        evap_clr;
    logic                        take;
    logic                        done;
    logic                        vld_d, evap_d;
    logic [RW-1:0]               row_d;
    logic [PW-1:0]               port_d;
    logic [AMT_W-1:0]            amt_d;

    // Per-port slots
    for (genvar i = 0; i < N; i++) begin : g_slot
        ph_upd_slot #(.RW(RW), .AMT_W(AMT_W)) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (i_upd_valid[i]),
            .in_dest   (i_upd_dest[i]),
            .in_amount (i_upd_amount[i]),
            .clr       (slot_clr[i]),
            .pending   (pend[i]),
            .dest      (slot_dest[i]),
            .amount    (slot_amt[i])
        );
        assign o_upd_ready[i] = ~pend[i];
        assign slot_clr[i]    = take && (gnt_idx == PW'(i));
    end

    // Round-robin pick: first pending port at or after rr_ptr, wrapping.
    always_comb begin : p_gnt
        int idx;
        any_pend = 1'b0;
        gnt_idx  = '0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any_pend && pend[idx]) begin
                any_pend = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

    assign done   = o_cmd_valid & i_cmd_ready;
    assign o_busy = (state_q != S_IDLE);

    // Next-state and next command register contents
    always_comb begin
        state_d  = state_q;
        vld_d    = o_cmd_valid;
        evap_d   = o_cmd_evap;
        row_d    = o_cmd_row;
        port_d   = o_cmd_port;
        amt_d    = o_cmd_amount;
        take     = 1'b0;
        evap_clr = 1'b0;
        case (state_q)
            S_IDLE, S_UPD: begin
                // Decision point: idle, or the outstanding update just completed.
                if (state_q == S_IDLE || done) begin
                    if (evap_req) begin
                        vld_d   = 1'b1;
                        evap_d  = 1'b1;
                        row_d   = '0;
                        port_d  = '0;
                        amt_d   = '0;
                        state_d = S_EVAP;
                    end else if (any_pend) begin
                        vld_d   = 1'b1;
                        evap_d  = 1'b0;
                        row_d   = slot_dest[gnt_idx];
                        port_d  = gnt_idx;
                        amt_d   = slot_amt[gnt_idx];
                        take    = 1'b1;
                        state_d = S_UPD;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_EVAP: begin
                if (done) begin
                    if (o_cmd_row != RW'(NODES - 1)) begin
                        row_d = o_cmd_row + RW'(1);
                    end else begin
                        // Sweep finished; always leave one idle cycle.
                        evap_clr = 1'b1;
                        vld_d    = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            o_cmd_valid  <= 1'b0;
            o_cmd_evap   <= 1'b0;
            o_cmd_row    <= '0;
            o_cmd_port   <= '0;
            o_cmd_amount <= '0;
            rr_ptr       <= '0;
        end else begin
            state_q      <= state_d;
            o_cmd_valid  <= vld_d;
            o_cmd_evap   <= evap_d;
            o_cmd_row    <= row_d;
            o_cmd_port   <= port_d;
            o_cmd_amount <= amt_d;
            if (take) rr_ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Evaporation timer. A wrap landing while a sweep is requested or running
    // is dropped rather than queued.
    assign evap_wrap = (evap_cnt == TW'(EVAP_PERIOD - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evap_cnt <= '0;
            evap_req <= 1'b0;
        end else begin
            evap_cnt <= evap_wrap ? '0 : evap_cnt + TW'(1);
            if (evap_clr)
                evap_req <= 1'b0;
            else if (evap_wrap && state_q != S_EVAP)
                evap_req <= 1'b1;
        end
    end

endmodule

// File: doc/ph_update_scheduler.md
Name: ph_update_scheduler

Overview:
- Sequences all writes into the per-router ACO pheromone table, which accepts one command per cycle.
- Takes backward-ant update requests from the N input ports, buffers one per port, and grants them round-robin.
- Interleaves a periodic evaporation sweep over every destination row.
- Sits between the input-port ant handlers and the pheromone-table storage next to the selection logic.

Parameters:
N, 5, number of input ports/requesters (port 0 = local)
NODES, 16, destination rows in the pheromone table
AMT_W, 3, width of the update amount (0..6 in use)
EVAP_PERIOD, 256, cycles between evaporation sweep starts (>= NODES+2)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_upd_valid  input  [0:N-1]  per-port update request
i_upd_dest  input  [0:N-1][$clog2(NODES)-1:0]  destination row of the ant
i_upd_amount  input  [0:N-1][AMT_W-1:0]  pheromone increment for that row/port
o_upd_ready  output  [0:N-1]  per-port holding slot free
o_cmd_valid  output  1  table command valid
i_cmd_ready  input  1  table accepts command this cycle
o_cmd_evap  output  1  1 = evaporation of row, 0 = update
o_cmd_row  output  $clog2(NODES)  target row
o_cmd_port  output  $clog2(N)  requesting port (update only, 0 for evap)
o_cmd_amount  output  AMT_W  increment (update only, 0 for evap)
o_busy  output  1  FSM not in S_IDLE

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on reset_n.
- Reset clears all of the following:
  - Outputs: o_cmd_valid=0, o_cmd_evap=0, o_cmd_row=0, o_cmd_port=0, o_cmd_amount=0, o_busy=0, o_upd_ready=all 1.
  - State: all pending slots empty, RR pointer=0, evap timer=0, evap_req=0, state=S_IDLE.
- Reset asserted mid-operation drops o_cmd_valid immediately; buffered requests and any partial sweep are lost.
- Per-port slot:
  - o_upd_ready[i] = ~pending[i].
  - Transfer on i_upd_valid[i] & o_upd_ready[i] at a rising edge; dest and amount are captured.
  - No accept is possible in the cycle a slot is freed; ready reasserts the following cycle.
- Zero amount: a transfer with amount==0 is accepted but never sets pending and never produces a command.
- Command register:
  - o_cmd_* fields are registered.
  - While o_cmd_valid=1 and i_cmd_ready=0, all o_cmd_* fields hold stable.
  - A command completes on o_cmd_valid & i_cmd_ready.
- Round-robin:
  - Search starts at the RR pointer and wraps modulo N; the first pending port wins.
  - On grant, the pointer moves to granted+1 mod N.
  - The granted slot is cleared on the same edge the command register loads.
- Latency: a request accepted at edge E0 appears as o_cmd_valid after edge E1 when the scheduler is idle (one cycle in the slot).
- Evaporation timer:
  - Free-running counter 0..EVAP_PERIOD-1.
  - On wrap it sets evap_req.
  - A wrap while evap_req=1 or a sweep is active is ignored (no queued second sweep).
- FSM:
  - S_IDLE:
    - evap_req -> load evap cmd, row 0, go S_EVAP.
    - Else any pending -> load RR-granted update, go S_UPD.
    - Else stay.
  - S_UPD, on completion:
    - evap_req -> load evap row 0, go S_EVAP.
    - Else any pending -> load next grant back-to-back, stay S_UPD.
    - Else o_cmd_valid=0, go S_IDLE.
  - S_EVAP, on completion:
    - row<NODES-1 -> load row+1, stay S_EVAP.
    - row==NODES-1 -> clear evap_req, o_cmd_valid=0, go S_IDLE (one bubble cycle before the next update).
- Priority and blocking:
  - Evaporation preempts updates only at command boundaries; an outstanding update is never abandoned.
  - Worst-case update blocking is NODES commands.
- Width rules:
  - o_cmd_port = $clog2(N) bits of the port index.
  - o_cmd_amount is passed through unmodified; saturation is the table's job.
- Simultaneous events:
  - Accepts on several ports in the same cycle are all captured.
  - An evap wrap in the same cycle as an update completion is seen at the next decision (registered evap_req).

Test Plan:
- Single request: port 2, dest 5, amount 3, table ready=1 -> o_cmd_valid one cycle after accept with evap=0, row 5, port 2, amount 3; o_upd_ready[2] returns 1 the cycle after the command loads.
- RR fairness: ports 0..4 request in the same cycle, pointer=0, ready=1 -> commands on 5 consecutive cycles with ports 0,1,2,3,4; a later request from ports 0 and 3 with pointer=0 -> 0 then 3.
- Backpressure: port 1 command valid, i_cmd_ready=0 for 4 cycles -> fields stable; port 1 ready stays 1; a second port-1 request is accepted into the slot and issued after the completion.
- Evaporation: EVAP_PERIOD=32, NODES=16, no updates -> at cycle 32 a sweep of rows 0..15 over 16 cycles, then o_busy=0. An update arriving mid-sweep issues after the one-cycle bubble.
- Zero amount: port 4 amount 0 -> o_upd_ready[4] stays 1, no command, RR pointer unchanged.
- Reset mid-sweep: assert reset_n=0 at row 7 -> o_cmd_valid=0 asynchronously; after release, timer restarts and the first sweep begins at row 0 after EVAP_PERIOD cycles.
